store_narrow: RTL
=================

# store_narrow

Store-path narrowing unit: accepts byte/halfword/word store requests from the 32-bit core and issues them as one or two 16-bit write beats on the halfword-wide data-memory bus. Beats carry byte enables. It is the write-side counterpart of the load-path sign extender, which widens 16-bit data to 32 bits. It sits between the execute stage's store port and the data-memory write interface.

## Interface
Parameters: none.

Clocking and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.

Ports:
- `clk` input 1 — clock; all state updates on the rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `req_valid` input 1 — store request present.
- `req_ready` output 1 — unit can accept a request; equals (state == IDLE).
- `req_addr` input 32 — byte address.
- `req_data` input 32 — store data, right-aligned.
- `req_size` input 2 — 00 byte, 01 half, 10 word, 11 reserved.
- `mem_valid` output 1 — write beat present.
- `mem_ready` input 1 — memory accepts beat.
- `mem_addr` output 32 — beat byte address; bit 0 always 0.
- `mem_wdata` output 16 — beat data.
- `mem_be` output 2 — byte enables; bit0 = lane [7:0], bit1 = lane [15:8].
- `done` output 1 — one-cycle pulse when a store completes.
- `err` output 1 — one-cycle pulse when a request is rejected.

## Operation
- State machine: IDLE, BEAT0, BEAT1.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, register addr/data/size, then:
    - reserved size → stay IDLE, pulse `err` next cycle.
    - byte or half → BEAT0.
    - word → BEAT0, with BEAT1 pending.
- Beat formatting (little-endian):
  - byte: `mem_addr` = {addr[31:1],0}; `mem_wdata` = {data[7:0],data[7:0]}; `mem_be` = 01 if addr[0]=0, else 10.
  - half: `mem_addr` = {addr[31:1],0}; `mem_wdata` = data[15:0]; `mem_be` = 11.
  - word beat0: `mem_addr` = {addr[31:2],00}; `mem_wdata` = data[15:0]; `mem_be` = 11.
  - word beat1: `mem_addr` = beat0 address + 2 (32-bit modulo); `mem_wdata` = data[31:16]; `mem_be` = 11.
- BEAT0 transitions, on `mem_valid` && `mem_ready`:
  - to BEAT1 if word;
  - otherwise to IDLE, with `done` pulsed next cycle.
- BEAT1 transition: on handshake, to IDLE with `done` pulsed next cycle.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0. Handling is per Configuration.
- `done` and `err` are never asserted in the same cycle.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready` = 1.
  - `mem_valid` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_be` = 00.
  - `done` = 0, `err` = 0.
- Latency and throughput:
  - `mem_valid` rises the cycle after request acceptance.
  - Zero memory stall: byte/half complete in 2 cycles, word in 3 cycles.
- Handshake:
  - Once `mem_valid` is high, addr/wdata/be stay stable until `mem_ready`.
  - `mem_valid` does not drop without a handshake.
- Back-to-back requests: `req_ready` reasserts in the same cycle `done` pulses.
- Rejected requests: an `err` request returns to IDLE with no mem traffic, so the next request is accepted the cycle `err` pulses.
- Reset mid-beat: `mem_valid` drops immediately (asynchronous). The pending beat is abandoned with no `done` and no `err`.
- Address wrap: a word store at 0xFFFFFFFC emits beat1 at 0xFFFFFFFE. A word store at 0xFFFFFFFE (unaligned, macro off) emits beats at 0xFFFFFFFC and 0xFFFFFFFE.

## Configuration
Macro `STORE_MISALIGN_TRAP_EN`:
- Defined:
  - A misaligned request is accepted, produces no mem beats, and pulses `err` the next cycle.
- Undefined:
  - Low address bits are forced to zero: half clears bit0, word clears bits[1:0].
  - The store proceeds normally.
  - `err` fires only for reserved size.

## Structure
- Shared package holds:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - state enum IDLE/BEAT0/BEAT1.
- One sub-module, `store_lane_pack`, is combinational: (addr, data, size, beat_sel) → (mem_addr, mem_wdata, mem_be).
- The top level owns the FSM and registers.

## Test plan
- Byte store, addr 0x1001, data 0x000000A5, `mem_ready` tied 1:
  - one beat: addr 0x1000, wdata 0xA5A5, be 10.
  - `done` two cycles after acceptance.
- Word store, addr 0x2000, data 0xDEADBEEF:
  - beat0: 0x2000 / 0xBEEF / 11.
  - beat1: 0x2002 / 0xDEAD / 11.
  - single `done`.
- Word store with `mem_ready` low for 3 cycles on beat0: beat held stable throughout, then beat1, then `done`.
- Half store, addr 0x3001:
  - macro on: no beat, `err` pulse.
  - macro off: beat addr 0x3000, be 11.
- Reserved size 11: `err` pulse, `mem_valid` stays 0, following byte store accepted and completes.
- Assert `rst` while beat1 is pending: `mem_valid` falls at once, outputs at reset values, no `done`.

Source files
------------

// File: rtl/store_narrow_pkg.sv
// store_narrow_pkg: size encodings, FSM states and the misalignment check shared by the store path.
package store_narrow_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
  function automatic logic misaligned(input logic [31:0] addr, input logic [1:0] size);
    return (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/store_narrow_if.sv
// store_narrow_if: core store request port plus halfword data-memory write port.
interface store_narrow_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        done;
  logic        err;
  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err
  );
  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err
  );
endinterface

// File: rtl/store_lane_pack.sv
// store_lane_pack: formats one little-endian 16-bit write beat from a 32-bit store.
module store_lane_pack
  import store_narrow_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        beat_sel,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be
);
  always_comb begin
    mem_addr  = beat_sel ? {addr[31:2], 2'b10} :
                size == SZ_WORD ? {addr[31:2], 2'b00} : {addr[31:1], 1'b0};
    mem_wdata = beat_sel ? data[31:16] : size == SZ_BYTE ? {2{data[7:0]}} : data[15:0];
    mem_be    = (size == SZ_BYTE && !beat_sel) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
  end
endmodule

// File: rtl/store_narrow.sv
// store_narrow: splits byte/half/word stores into one or two 16-bit write beats.
// STORE_MISALIGN_TRAP_EN rejects misaligned stores with err instead of aligning them down.
module store_narrow
  import store_narrow_pkg::*;
(
  input logic clk,
  input logic rst,
  store_narrow_if.slave bus
);
  state_t      state;
  logic [31:0] addr_q, data_q;
  logic [1:0]  size_q;
  logic [31:0] pk_addr;
  logic [15:0] pk_wdata;
  logic [1:0]  pk_be;
  logic        idle, hs, bad;
  assign idle = state == IDLE;
  assign hs = bus.mem_valid && bus.mem_ready;
  assign bus.req_ready = idle;
`ifdef STORE_MISALIGN_TRAP_EN
  assign bad = bus.req_size == SZ_RSVD || misaligned(bus.req_addr, bus.req_size);
`else
  assign bad = bus.req_size == SZ_RSVD;
`endif
  // In IDLE the packer formats beat0 from the live request; otherwise beat1 from the held copy.
  store_lane_pack u_pack (
    .addr(idle ? bus.req_addr : addr_q),
    .data(idle ? bus.req_data : data_q),
    .size(idle ? bus.req_size : size_q),
    .beat_sel(!idle),
    .mem_addr(pk_addr),
    .mem_wdata(pk_wdata),
    .mem_be(pk_be)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      size_q        <= SZ_BYTE;
      bus.mem_valid <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          addr_q <= bus.req_addr;
          data_q <= bus.req_data;
          size_q <= bus.req_size;
          if (bad) bus.err <= 1'b1;
          else begin
            state         <= BEAT0;
            bus.mem_valid <= 1'b1;
            bus.mem_addr  <= pk_addr;
            bus.mem_wdata <= pk_wdata;
            bus.mem_be    <= pk_be;
          end
        end
        BEAT0: if (hs) begin
          if (size_q == SZ_WORD) begin
            state         <= BEAT1;
            bus.mem_addr  <= pk_addr;
            bus.mem_wdata <= pk_wdata;
            bus.mem_be    <= pk_be;
          end else begin
            state         <= IDLE;
            bus.mem_valid <= 1'b0;
            bus.done      <= 1'b1;
          end
        end
        BEAT1: if (hs) begin
          state         <= IDLE;
          bus.mem_valid <= 1'b0;
          bus.done      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
